echo_processor: RTL

Parametrised delay-line echo processor sitting between `spi2adc` and `spi2dac` in the 10 kHz audio path, replacing the fixed `processor` block. Each ADC sample is stored in a circular buffer of 2^AW words, and a sample from a runtime-selectable delay is read back. The output is bypass, feed-forward echo, feedback echo or pure delay, with programmable attenuation and saturation. Samples are offset-binary in and out, with mid-scale = silence.

---
 rtl/echo_processor.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/echo_processor.sv
// echo_processor: delay-line echo processor for the 10 kHz audio path.
// Each accepted ADC sample is written into a circular buffer of 2^AW words.
// A sample from a runtime-selectable delay is read back and combined with the
// input as bypass, feed-forward echo, feedback echo or pure delay.
// Ports:
//   sysclk     system clock
//   rst        asynchronous active-high reset
//   data_valid one-cycle pulse, new sample on data_in (ignored while busy)
//   data_in    ADC sample, offset binary
//   delay      echo delay in samples (0 behaves as 1)
//   mode       00 bypass, 01 feed-forward, 10 feedback, 11 delay-only
//   gain_sh    echo attenuation 2^-(gain_sh+1)
//   data_out   processed sample, offset binary, registered
//   out_valid  one-cycle pulse when data_out updates
//   busy       high while a sample is in flight
module echo_processor #(
  parameter int DW = 10,
  parameter int AW = 13
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic          data_valid,
  input  logic [DW-1:0] data_in,
  input  logic [AW-1:0] delay,
  input  logic [1:0]    mode,
  input  logic [1:0]    gain_sh,
  output logic [DW-1:0] data_out,
  output logic          out_valid,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RD, CALC, WR} state_t;

  localparam logic [AW-1:0]        FILL_MAX = '1;
  localparam logic [AW-1:0]        ONE      = AW'(1);
  localparam logic signed [DW-1:0] S_MAX    = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] S_MIN    = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]        MID      = {1'b1, {(DW-1){1'b0}}};

  // Clip a DW+1 bit sum back into the signed DW-bit range.
  function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] v);
    if (v[DW] != v[DW-1]) return v[DW] ? S_MIN : S_MAX;
    return v[DW-1:0];
  endfunction

  // Control state (reset)
  state_t        state_q, state_d;
  logic          dv_q, dv_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          out_valid_q, out_valid_d;

  // Datapath state (no reset)
  logic [DW-1:0]        din_q, din_d;
  logic [AW-1:0]        dly_in_q, dly_in_d;
  logic [1:0]           mode_in_q, mode_in_d;
  logic [1:0]           gain_in_q, gain_in_d;
  logic signed [DW-1:0] xs_q, xs_d;
  logic [AW-1:0]        d_q, d_d;
  logic [1:0]           mode_q, mode_d;
  logic [1:0]           gain_q, gain_d;
  logic                 hit_q, hit_d;
  logic signed [DW-1:0] store_q, store_d;

  logic signed [DW-1:0] mem [2**AW];
  logic signed [DW-1:0] rd_data_q;
  logic [AW-1:0]        rd_addr;
  logic                 we;

  logic signed [DW-1:0] ds, e, y_sat, y, st;
  logic signed [DW:0]   sum;
  logic [2:0]           shamt;

  assign busy      = (state_q != IDLE);
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  // D >= 1 keeps the read address away from the word being written.
  assign rd_addr   = wp_q - d_q;

  // Echo arithmetic; only consumed in CALC.
  always_comb begin
    ds    = hit_q ? rd_data_q : '0;
    shamt = {1'b0, gain_q} + 3'd1;
    e     = ds >>> shamt;
    sum   = {xs_q[DW-1], xs_q} + {e[DW-1], e};
    y_sat = sat(sum);
    y     = xs_q;
    st    = xs_q;
    case (mode_q)
      2'b01:   y = y_sat;
      2'b10: begin
        y  = y_sat;
        st = y_sat;
      end
      2'b11:   y = ds;
      default: y = xs_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    // Pulses that arrive while a sample is in flight are dropped here.
    dv_d        = data_valid & ~busy;
    wp_d        = wp_q;
    fill_d      = fill_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    din_d       = data_in;
    dly_in_d    = delay;
    mode_in_d   = mode;
    gain_in_d   = gain_sh;
    xs_d        = xs_q;
    d_d         = d_q;
    mode_d      = mode_q;
    gain_d      = gain_q;
    hit_d       = hit_q;
    store_d     = store_q;
    we          = 1'b0;
    case (state_q)
      IDLE: begin
        if (dv_q) begin
          xs_d    = {~din_q[DW-1], din_q[DW-2:0]};
          d_d     = (dly_in_q == '0) ? ONE : dly_in_q;
          mode_d  = mode_in_q;
          gain_d  = gain_in_q;
          state_d = RD;
        end
      end
      RD: begin
        // Words not yet written since reset read as silence.
        hit_d   = (d_q <= fill_q);
        state_d = CALC;
      end
      CALC: begin
        data_out_d  = {~y[DW-1], y[DW-2:0]};
        out_valid_d = 1'b1;
        store_d     = st;
        state_d     = WR;
      end
      WR: begin
        we      = 1'b1;
        wp_d    = wp_q + ONE;
        fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + ONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dv_q        <= 1'b0;
      wp_q        <= '0;
      fill_q      <= '0;
      data_out_q  <= MID;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dv_q        <= dv_d;
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge sysclk) begin
    din_q     <= din_d;
    dly_in_q  <= dly_in_d;
    mode_in_q <= mode_in_d;
    gain_in_q <= gain_in_d;
    xs_q      <= xs_d;
    d_q       <= d_d;
    mode_q    <= mode_d;
    gain_q    <= gain_d;
    hit_q     <= hit_d;
    store_q   <= store_d;
  end

  // Sample buffer: synchronous write, 1-cycle synchronous read.
  always_ff @(posedge sysclk) begin
    if (we) mem[wp_q] <= store_q;
    if (state_q == RD) rd_data_q <= mem[rd_addr];
  end

endmodule
